// File: rtl/ip_operand_loader.sv
// ip_operand_loader: gathers a serial byte stream into a weight vector and an
// input vector for a downstream inner-product unit. It waits out the unit's
// pipeline latency, captures the result and holds it until it is taken.
//
// Build option IP_LOADER_WEIGHT_HOLD_EN: keeps the loaded weights across
// results, so later vectors only need the X bytes. iWeightReload forces a new
// weight load.
module ip_operand_loader #(
    parameter int BIT_WIDTH    = 8,
    parameter int NUM_OF_INPUT = 16,
    parameter int IP_LATENCY   = 1
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [BIT_WIDTH-1:0]              iData,
    input  logic                              iValid,
    output logic                              oReady,
    output logic [NUM_OF_INPUT*BIT_WIDTH-1:0] oW_bus,
    output logic [NUM_OF_INPUT*BIT_WIDTH-1:0] oX_bus,
    input  logic [BIT_WIDTH-1:0]              iInnerout,
    output logic [BIT_WIDTH-1:0]              oResult,
    output logic                              oResultValid,
    input  logic                              iResultReady,
    input  logic                              iWeightReload
);

    localparam int LANE_W = (NUM_OF_INPUT > 1) ? $clog2(NUM_OF_INPUT) : 1;
    localparam int WAIT_W = (IP_LATENCY > 0) ? $clog2(IP_LATENCY + 1) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_OF_INPUT - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(IP_LATENCY);

    typedef enum logic [1:0] {
        LOAD_W = 2'd0,
        LOAD_X = 2'd1,
        WAIT   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t              state;
    logic [LANE_W-1:0]   lane_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                accept;
    logic                hold_w;

    assign accept = iValid && oReady;

`ifdef IP_LOADER_WEIGHT_HOLD_EN
    logic weights_loaded;

    // Remember that a complete weight vector is sitting on oW_bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            weights_loaded <= 1'b0;
        else if (state == LOAD_W && accept && lane_cnt == LAST_LANE)
            weights_loaded <= 1'b1;
    end

    assign hold_w = weights_loaded && !iWeightReload;
`else
    logic unused_reload;

    assign unused_reload = iWeightReload;
    assign hold_w        = 1'b0;
`endif

    // Load/wait/present sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= LOAD_W;
            lane_cnt     <= '0;
            wait_cnt     <= '0;
            oW_bus       <= '0;
            oX_bus       <= '0;
            oResult      <= '0;
            oResultValid <= 1'b0;
            oReady       <= 1'b1;
        end else begin
            case (state)
                LOAD_W: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_OF_INPUT; k++)
                            if (lane_cnt == LANE_W'(k))
                                oW_bus[k*BIT_WIDTH +: BIT_WIDTH] <= iData;
                        if (lane_cnt == LAST_LANE) begin
                            lane_cnt <= '0;
                            state    <= LOAD_X;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (accept) begin
                        for (int k = 0; k < NUM_OF_INPUT; k++)
                            if (lane_cnt == LANE_W'(k))
                                oX_bus[k*BIT_WIDTH +: BIT_WIDTH] <= iData;
                        if (lane_cnt == LAST_LANE) begin
                            lane_cnt <= '0;
                            wait_cnt <= '0;
                            oReady   <= 1'b0;
                            state    <= WAIT;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // IP_LATENCY+1 edges: the unit's pipeline plus its input register.
                    if (wait_cnt == LAST_WAIT) begin
                        oResult      <= iInnerout;
                        oResultValid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (iResultReady) begin
                        oResultValid <= 1'b0;
                        oReady       <= 1'b1;
                        state        <= hold_w ? LOAD_X : LOAD_W;
                    end
                end
                default: state <= LOAD_W;
            endcase
        end
    end

endmodule

// File: doc/ip_operand_loader.md
IP_OPERAND_LOADER -- requirements
Module: ip_operand_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 8: operand and result width.
REQ-002 Parameter NUM_OF_INPUT, default 16: lanes per vector.
REQ-003 Parameter IP_LATENCY, default 1: register stages in the downstream inner-product unit.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk, input, 1, clock.
- resetn, input, 1, reset, asynchronous, active-low.
- iData, input, BIT_WIDTH, serial operand byte.
- iValid, input, 1, iData valid.
- oReady, output, 1, loader accepts iData.
- oW_bus, output, NUM_OF_INPUT*BIT_WIDTH, weight lanes; lane k is bits [8k+7:8k].
- oX_bus, output, NUM_OF_INPUT*BIT_WIDTH, input lanes; same packing as oW_bus.
- iInnerout, input, BIT_WIDTH, result from the inner-product unit.
- oResult, output, BIT_WIDTH, captured result.
- oResultValid, output, 1, oResult valid.
- iResultReady, input, 1, downstream accepts oResult.
- iWeightReload, input, 1, forces a weight reload; used only in the configuration of REQ-020.

Function
REQ-005 A byte is accepted on a rising clk edge only when iValid=1 and oReady=1.
REQ-006 States are LOAD_W, LOAD_X, WAIT and OUT; oReady=1 only in LOAD_W and LOAD_X.
REQ-007 In LOAD_W, the accepted byte with lane counter value n is written to oW_bus lane n, and the counter increments.
- When the byte at n=NUM_OF_INPUT-1 is accepted, the counter wraps to 0 and the state goes to LOAD_X.
REQ-008 LOAD_X behaves the same as LOAD_W but writes oX_bus.
- The final byte goes to WAIT and clears the wait counter.
REQ-009 Bus registers change only on an accepted byte; unwritten lanes hold their previous values.
REQ-010 WAIT lasts exactly IP_LATENCY+1 cycles.
- On its final edge: oResult <= iInnerout, oResultValid <= 1, state goes to OUT.
- With default parameters, oResultValid rises on the 2nd edge after the last X byte is accepted.
REQ-011 In OUT, oResult and oResultValid hold stable until iResultReady=1.
REQ-012 On the oResultValid and iResultReady handshake edge, oResultValid <= 0 and the next state is selected per REQ-019/REQ-020.
REQ-013 iValid asserted in WAIT or OUT is ignored; no byte is consumed.
REQ-014 Gaps in iValid stall the lane counter; no timeout applies.
REQ-015 iResultReady=1 outside OUT has no effect.

Reset
REQ-016 Asserting resetn low immediately forces:
- state LOAD_W, lane and wait counters 0;
- oW_bus, oX_bus and oResult all zero;
- oResultValid 0, oReady 1 once released.
REQ-017 Reset mid-load discards the partial vector; the first byte after release goes to oW_bus lane 0.
REQ-018 A pending oResult is lost on reset.

Configuration
REQ-019 Without IP_LOADER_WEIGHT_HOLD_EN:
- each result handshake returns to LOAD_W;
- every vector is 2*NUM_OF_INPUT bytes;
- iWeightReload is ignored.
REQ-020 With IP_LOADER_WEIGHT_HOLD_EN defined, an internal weights_loaded flag is set on LOAD_W completion and cleared by reset.
- The result handshake goes to LOAD_X if weights_loaded=1 and iWeightReload=0 at that edge; otherwise it goes to LOAD_W.
- oW_bus is retained across vectors in LOAD_X-only operation.

Verification
REQ-021 Basic load and capture:
- Stimulus: stream W=0x01..0x10 then X=0x11..0x20 with iValid held high; the bench model drives iInnerout=0x5A.
- Response: oW_bus[7:0]=0x01, oW_bus[127:120]=0x10, oX_bus[7:0]=0x11, oX_bus[127:120]=0x20; oResultValid=1 with oResult=0x5A two edges after the 32nd accept.
REQ-022 Backpressure:
- Stimulus: iResultReady low for 5 cycles in OUT, with iValid=1 and data 0xFF.
- Response: oResult holds 0x5A, oReady=0, buses unchanged; after ready rises, one handshake occurs, then oReady=1 and state is LOAD_W.
REQ-023 Stalled input:
- Stimulus: iValid toggles 1/0 every cycle through a full vector.
- Response: 32 accepts over 64 cycles, lanes identical to REQ-021, result timing relative to the last accept unchanged.
REQ-024 Reset mid-load:
- Stimulus: assert resetn after 7 W bytes, then stream a full vector 0xA0..0xBF.
- Response: during reset all buses and oResult read 0; afterwards oW_bus[7:0]=0xA0 and oX_bus[127:120]=0xBF.
REQ-025 Weight hold (IP_LOADER_WEIGHT_HOLD_EN defined):
- Stimulus: after REQ-021, stream 16 bytes 0x30..0x3F with iWeightReload=0; then set iWeightReload=1 at the next handshake.
- Response: the second result needs only 16 accepts, oW_bus unchanged, oX_bus[7:0]=0x30; after the reload handshake the state is LOAD_W.
